uart_rx_unit: RTL and testbench

- Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit (8N1), LSB first, line idles high.
- Converts the serial line into parallel bytes with a one-cycle valid strobe and a framing-error flag.
- Sits beside the CPU top level on the host serial link. It decodes the program's UART TX output, and it also serves as the building block for the CPU's RX path.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx_unit.sv | 110 +++++++++++
 tb/tb_uart_rx_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the receiver top level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is a parameter so idle-high lines start idle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Emits a one-cycle strobe with the byte and a framing flag.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
  output logic [7:0] rdata,
  output logic       rdata_ready,
  output logic       ferr,
  input  logic       rxd,
  input  logic       clk,
  input  logic       rstn
);

  localparam int CW = $clog2(2 * CLK_PER_HALF_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic                 rxs;
  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [7:0]           rdata_n;
  logic                 ready_n;
  logic                 ferr_n;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (rxd),
    .q   (rxs)
  );

  // state, counters and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rdata       <= '0;
      rdata_ready <= 1'b0;
      ferr        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      rdata       <= rdata_n;
      rdata_ready <= ready_n;
      ferr        <= ferr_n;
    end
  end

  // frame sequencing: start detect, mid-bit sampling, stop check
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shreg_n = shreg;
    rdata_n = rdata;
    ready_n = 1'b0;
    ferr_n  = ferr;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          idx_n = '0;
          // a high line at mid-start is a glitch
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_n        = '0;
          shreg_n[idx] = rxs;
          if (idx == LAST_IDX) begin
            state_n = STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          rdata_n = shreg;
          ferr_n  = ~rxs;
          ready_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed plus random frame bench for uart_rx_unit.
// Expected bytes come from the frames the bench itself sends.
module tb_uart_rx_unit;

  localparam int H   = 30;
  localparam int BIT = 2 * H;

  logic       clk;
  logic       rstn;
  logic       rxd;
  logic [7:0] rdata;
  logic       rdata_ready;
  logic       ferr;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [8:0] last_exp;

  uart_rx_unit #(
    .CLK_PER_HALF_BIT(H)
  ) dut (
    .rdata      (rdata),
    .rdata_ready(rdata_ready),
    .ferr       (ferr),
    .rxd        (rxd),
    .clk        (clk),
    .rstn       (rstn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // every strobe cycle is logged as {ferr, rdata}
  always @(negedge clk) begin
    if (rdata_ready === 1'b1) got_q.push_back({ferr, rdata});
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(logic b, int per);
    rxd = b;
    repeat (per) @(negedge clk);
  endtask

  // model: a frame yields its byte, ferr is the inverse of the stop level
  task automatic send(logic [7:0] d, logic stopb, int per);
    drive_bit(1'b0, per);
    for (int i = 0; i < 8; i++) drive_bit(d[i], per);
    drive_bit(stopb, per);
    exp_q.push_back({~stopb, d});
    last_exp = {~stopb, d};
  endtask

  task automatic check_rx(string tag);
    int n;
    int budget;
    n = exp_q.size();
    budget = 0;
    while (got_q.size() < n && budget < 4 * BIT) begin
      @(negedge clk);
      budget++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) begin
        chk({tag, "_data"}, got_q[i][7:0], exp_q[i][7:0]);
        chk({tag, "_ferr"}, got_q[i][8], exp_q[i][8]);
      end
    end
    chk({tag, "_hold"}, {ferr, rdata}, last_exp);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       sb;
    rstn = 1'b0;
    rxd  = 1'b1;
    last_exp = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_ready", rdata_ready, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    rstn = 1'b1;
    idle(20);

    send(8'hAA, 1'b1, BIT);
    check_rx("aa");

    send(8'h55, 1'b0, BIT);
    idle(3 * BIT);
    check_rx("55_bad_stop");
    send(8'h3C, 1'b1, BIT);
    check_rx("3c");

    drive_bit(1'b0, 10);
    idle(H + 20);
    check_rx("glitch");
    send(8'h12, 1'b1, BIT);
    check_rx("12");

    send(8'h00, 1'b1, BIT);
    send(8'hFF, 1'b1, BIT);
    send(8'h01, 1'b1, BIT);
    check_rx("b2b");

    drive_bit(1'b0, BIT);
    drive_bit(1'b0, BIT);
    drive_bit(1'b1, BIT);
    drive_bit(1'b1, H);
    #2;
    rstn = 1'b0;
    rxd  = 1'b1;
    #1;
    chk("async_rst_rdata", rdata, 8'h00);
    chk("async_rst_ready", rdata_ready, 1'b0);
    chk("async_rst_ferr", ferr, 1'b0);
    @(negedge clk);
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    last_exp = '0;
    idle(2 * BIT);
    check_rx("rst_abort");
    send(8'hC3, 1'b1, BIT);
    check_rx("c3");

    send(8'hA5, 1'b1, BIT + 2);
    idle(BIT);
    check_rx("a5_slow");
    send(8'hA5, 1'b1, BIT - 2);
    idle(BIT);
    check_rx("a5_fast");

    for (int k = 0; k < 8; k++) begin
      d  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      send(d, sb, BIT);
      if (!sb) idle(3 * BIT);
      else idle($urandom_range(0, 40));
      check_rx("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
